// File: rtl/lenet_pkg.sv
// Shared LeNet pipeline constants: conv/activation widths, default map size and saturation helper.
package lenet_pkg;

   localparam int unsigned CONV_OUT_WIDTH = 32;
   localparam int unsigned ACT_WIDTH      = 8;
   localparam int unsigned MAP_W_DEF      = 10;
   localparam int unsigned MAP_H_DEF      = 10;

   // Largest positive value representable in a signed field of the given width.
   function automatic longint unsigned sat_max(input int unsigned width);
      return (longint'(1) << (width - 1)) - 1;
   endfunction

endpackage

// File: rtl/pool_row_buf.sv
// One-row holding buffer for horizontal pair maxima; 1 write port, 1 async read port, no reset.
module pool_row_buf #(
   parameter int unsigned DEPTH = 5,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/relu_maxpool22.sv
// ReLU + 2x2/stride-2 max pooling + requantization over a raster conv stream.
// Define RELU_MAXPOOL_ROUND_EN for round-half-up requantization instead of truncation.
module relu_maxpool22
   import lenet_pkg::*;
#(
   parameter int unsigned IN_WIDTH  = CONV_OUT_WIDTH,
   parameter int unsigned OUT_WIDTH = ACT_WIDTH,
   parameter int unsigned MAP_W     = MAP_W_DEF,
   parameter int unsigned MAP_H     = MAP_H_DEF,
   parameter int unsigned SHIFT     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [IN_WIDTH-1:0]  in_data,
   output logic                 out_valid,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_last
);

   localparam int unsigned BufDepth = MAP_W / 2;
   localparam int unsigned BufAw    = (BufDepth > 1) ? $clog2(BufDepth) : 1;
   localparam int unsigned ColW     = (MAP_W > 1) ? $clog2(MAP_W) : 1;
   localparam int unsigned RowW     = (MAP_H > 1) ? $clog2(MAP_H) : 1;
   localparam logic [ColW-1:0] ColLast = ColW'(MAP_W - 1);
   localparam logic [RowW-1:0] RowLast = RowW'(MAP_H - 1);
   localparam int unsigned RndSh    = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [IN_WIDTH:0] SatMax = (IN_WIDTH + 1)'(sat_max(OUT_WIDTH));
`ifdef RELU_MAXPOOL_ROUND_EN
   localparam logic [IN_WIDTH:0] RoundAdd =
      (SHIFT > 0) ? ((IN_WIDTH + 1)'(1) << RndSh) : '0;
`else
   localparam logic [IN_WIDTH:0] RoundAdd = '0;
`endif

   if ((MAP_W % 2) != 0) begin : g_bad_map_w
      $error("relu_maxpool22: MAP_W must be even");
   end
   if ((MAP_H % 2) != 0) begin : g_bad_map_h
      $error("relu_maxpool22: MAP_H must be even");
   end

   logic [ColW-1:0]      col_q, col_d;
   logic [RowW-1:0]      row_q, row_d;
   logic [IN_WIDTH-1:0]  h_max_q, h_max_d;
   logic                 out_valid_q, out_valid_d;
   logic                 out_last_q, out_last_d;
   logic [OUT_WIDTH-1:0] out_data_q, out_data_d;

   logic [IN_WIDTH-1:0]  relu_val, pair_max, pool_max, buf_rdata;
   logic [IN_WIDTH:0]    rq_sum, rq_shift, rq_sat;
   logic                 buf_we;
   logic [BufAw-1:0]     buf_addr;

   assign buf_addr = BufAw'(col_q >> 1);

   pool_row_buf #(
      .DEPTH (BufDepth),
      .WIDTH (IN_WIDTH),
      .AW    (BufAw)
   ) u_row_buf (
      .clk   (clk),
      .we    (buf_we & ~rst),
      .waddr (buf_addr),
      .wdata (pair_max),
      .raddr (buf_addr),
      .rdata (buf_rdata)
   );

   always_comb begin
      relu_val = in_data[IN_WIDTH-1] ? '0 : in_data;
      // All operands are non-negative after ReLU, so unsigned compares suffice.
      pair_max = (relu_val > h_max_q) ? relu_val : h_max_q;
      pool_max = (buf_rdata > pair_max) ? buf_rdata : pair_max;
      rq_sum   = {1'b0, pool_max} + RoundAdd;
      rq_shift = rq_sum >> SHIFT;
      rq_sat   = (rq_shift > SatMax) ? SatMax : rq_shift;

      col_d       = col_q;
      row_d       = row_q;
      h_max_d     = h_max_q;
      buf_we      = 1'b0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_data_d  = out_data_q;

      if (in_valid) begin
         if (col_q == ColLast) begin
            col_d = '0;
            row_d = (row_q == RowLast) ? '0 : row_q + RowW'(1);
         end else begin
            col_d = col_q + ColW'(1);
         end

         case ({row_q[0], col_q[0]})
            2'b00, 2'b10: h_max_d = relu_val;
            2'b01:        buf_we  = 1'b1;
            default: begin
               out_valid_d = 1'b1;
               out_data_d  = rq_sat[OUT_WIDTH-1:0];
               out_last_d  = (row_q == RowLast) && (col_q == ColLast);
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q       <= '0;
         row_q       <= '0;
         h_max_q     <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         h_max_q     <= h_max_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_relu_maxpool22.sv
// Bench for relu_maxpool22: two 4x4 instances (SHIFT=0 and SHIFT=8) share one stimulus stream.
module tb_relu_maxpool22;

`ifdef RELU_MAXPOOL_ROUND_EN
   localparam bit Round = 1'b1;
`else
   localparam bit Round = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_data;
   logic        o0_valid, o0_last, o8_valid, o8_last;
   logic [7:0]  o0_data, o8_data;

   int errors = 0;
   int checks = 0;

   longint frame [16];
   int     q0_idx[$], q8_idx[$], e_idx[$];
   longint q0_data[$], q8_data[$], e0_data[$], e8_data[$];
   bit     q0_last[$], q8_last[$], e_last[$];

   always #5 clk = ~clk;

   relu_maxpool22 #(
      .IN_WIDTH (32), .OUT_WIDTH (8), .MAP_W (4), .MAP_H (4), .SHIFT (0)
   ) dut0 (
      .clk (clk), .rst (rst), .in_valid (in_valid), .in_data (in_data),
      .out_valid (o0_valid), .out_data (o0_data), .out_last (o0_last)
   );

   relu_maxpool22 #(
      .IN_WIDTH (32), .OUT_WIDTH (8), .MAP_W (4), .MAP_H (4), .SHIFT (8)
   ) dut8 (
      .clk (clk), .rst (rst), .in_valid (in_valid), .in_data (in_data),
      .out_valid (o8_valid), .out_data (o8_data), .out_last (o8_last)
   );

   // Reference: largest ReLU'd value in 2x2 block k of the current frame.
   function automatic longint pooled(input int k);
      longint m = 0;
      int br = k / 2;
      int bc = k % 2;
      for (int dr = 0; dr < 2; dr++)
         for (int dc = 0; dc < 2; dc++)
            if (frame[(2 * br + dr) * 4 + 2 * bc + dc] > m)
               m = frame[(2 * br + dr) * 4 + 2 * bc + dc];
      return m;
   endfunction

   function automatic longint requant(input longint p, input int shift);
      longint q = p;
      if (Round && shift > 0) q = q + (longint'(1) << (shift - 1));
      q = q >>> shift;
      if (q > 127) q = 127;
      return q;
   endfunction

   task automatic clear_q();
      q0_idx.delete(); q8_idx.delete(); e_idx.delete();
      q0_data.delete(); q8_data.delete(); e0_data.delete(); e8_data.delete();
      q0_last.delete(); q8_last.delete(); e_last.delete();
   endtask

   // Drive one cycle, then record any output pulse tagged with the sample index just accepted.
   task automatic step(input bit v, input longint d, input int idx);
      in_valid = v;
      in_data  = d[31:0];
      @(posedge clk);
      #1;
      if (o0_valid) begin
         q0_idx.push_back(idx); q0_data.push_back(longint'(o0_data)); q0_last.push_back(o0_last);
      end
      if (o8_valid) begin
         q8_idx.push_back(idx); q8_data.push_back(longint'(o8_data)); q8_last.push_back(o8_last);
      end
   endtask

   task automatic play_frame(input bit gaps);
      for (int i = 0; i < 16; i++) begin
         if ((i % 2) == 1 && ((i / 4) % 2) == 1) begin
            e_idx.push_back(i);
            e_last.push_back(i == 15);
            e0_data.push_back(requant(pooled((i / 8) * 2 + (i % 4) / 2), 0));
            e8_data.push_back(requant(pooled((i / 8) * 2 + (i % 4) / 2), 8));
         end
         step(1'b1, frame[i], i);
         if (gaps) step(1'b0, 0, -1);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(1'b0, 0, -1);
      step(1'b0, 0, -1);
      checks++; if (o0_valid !== 1'b0) begin errors++; $display("FAIL reset_valid0 got %b want 0", o0_valid); end
      checks++; if (o0_last !== 1'b0) begin errors++; $display("FAIL reset_last0 got %b want 0", o0_last); end
      checks++; if (o0_data !== 8'd0) begin errors++; $display("FAIL reset_data0 got %0d want 0", o0_data); end
      checks++; if (o8_valid !== 1'b0) begin errors++; $display("FAIL reset_valid8 got %b want 0", o8_valid); end
      checks++; if (o8_data !== 8'd0) begin errors++; $display("FAIL reset_data8 got %0d want 0", o8_data); end
      rst = 1'b0;
      clear_q();
   endtask

   task automatic test_ramp(input bit gaps);
      for (int i = 0; i < 16; i++) frame[i] = i + 1;
      clear_q();
      play_frame(gaps);
      checks++;
      if (q0_data.size() != 4 || q8_data.size() != 4) begin
         errors++;
         $display("FAIL ramp%0d_count got %0d/%0d want 4", gaps, q0_data.size(), q8_data.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (q0_idx[k] != e_idx[k] || q0_data[k] != e0_data[k] || q0_last[k] != e_last[k]) begin
               errors++;
               $display("FAIL ramp%0d_out0[%0d] got idx=%0d d=%0d l=%0d want idx=%0d d=%0d l=%0d",
                        gaps, k, q0_idx[k], q0_data[k], q0_last[k], e_idx[k], e0_data[k], e_last[k]);
            end
            checks++;
            if (q8_idx[k] != e_idx[k] || q8_data[k] != e8_data[k] || q8_last[k] != e_last[k]) begin
               errors++;
               $display("FAIL ramp%0d_out8[%0d] got idx=%0d d=%0d l=%0d want idx=%0d d=%0d l=%0d",
                        gaps, k, q8_idx[k], q8_data[k], q8_last[k], e_idx[k], e8_data[k], e_last[k]);
            end
         end
      end
      step(1'b0, 0, -1);
      checks++;
      if (o0_valid !== 1'b0 || o0_last !== 1'b0 || o0_data !== 8'd16) begin
         errors++;
         $display("FAIL ramp%0d_hold got v=%b l=%b d=%0d want v=0 l=0 d=16",
                  gaps, o0_valid, o0_last, o0_data);
      end
   endtask

   task automatic test_negative();
      for (int i = 0; i < 16; i++) frame[i] = -5;
      clear_q();
      play_frame(1'b0);
      checks++;
      if (q0_data.size() != 4 || q8_data.size() != 4) begin
         errors++;
         $display("FAIL neg_count got %0d/%0d want 4", q0_data.size(), q8_data.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (q0_data[k] != 0 || q8_data[k] != 0 || q0_last[k] != e_last[k]
                || q0_idx[k] != e_idx[k]) begin
               errors++;
               $display("FAIL neg_out[%0d] got d0=%0d d8=%0d l=%0d idx=%0d want 0 0 l=%0d idx=%0d",
                        k, q0_data[k], q8_data[k], q0_last[k], q0_idx[k], e_last[k], e_idx[k]);
            end
         end
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 16; i++) frame[i] = -longint'($urandom_range(1, 1000));
      frame[0]  = 64'h7FFF_FFFF;
      frame[7]  = 384;
      frame[9]  = 64'h7FFF_FFFF;
      frame[10] = 384;
      frame[14] = 100;
      clear_q();
      play_frame(1'b0);
      checks++;
      if (q8_data.size() != 4 || q0_data.size() != 4) begin
         errors++;
         $display("FAIL sat_count got %0d/%0d want 4", q0_data.size(), q8_data.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (q0_data[k] != e0_data[k] || q8_data[k] != e8_data[k] || q8_last[k] != e_last[k]) begin
               errors++;
               $display("FAIL sat_out[%0d] got d0=%0d d8=%0d l=%0d want d0=%0d d8=%0d l=%0d",
                        k, q0_data[k], q8_data[k], q8_last[k], e0_data[k], e8_data[k], e_last[k]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      for (int i = 0; i < 6; i++) step(1'b1, 100 + i, -1);
      rst = 1'b1;
      step(1'b1, 1000, -1);
      checks++;
      if (o0_valid !== 1'b0 || o8_valid !== 1'b0) begin
         errors++;
         $display("FAIL midrst_cancel got v0=%b v8=%b want 0 0", o0_valid, o8_valid);
      end
      rst = 1'b0;
      for (int i = 0; i < 16; i++) frame[i] = i + 1;
      clear_q();
      play_frame(1'b0);
      checks++;
      if (q0_data.size() != 4 || q8_data.size() != 4) begin
         errors++;
         $display("FAIL midrst_count got %0d/%0d want 4", q0_data.size(), q8_data.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (q0_idx[k] != e_idx[k] || q0_data[k] != e0_data[k] || q0_last[k] != e_last[k]) begin
               errors++;
               $display("FAIL midrst_out[%0d] got idx=%0d d=%0d l=%0d want idx=%0d d=%0d l=%0d",
                        k, q0_idx[k], q0_data[k], q0_last[k], e_idx[k], e0_data[k], e_last[k]);
            end
         end
      end
   endtask

   task automatic test_back_to_back(input int nframes, input bit randomize);
      clear_q();
      for (int f = 0; f < nframes; f++) begin
         for (int i = 0; i < 16; i++) begin
            if (!randomize) frame[i] = (f == 0) ? i + 1 : 16 - i;
            else if ($urandom_range(0, 1) == 1) frame[i] = longint'(int'($urandom));
            else frame[i] = longint'($urandom_range(0, 60000)) - 30000;
         end
         play_frame(1'b0);
      end
      checks++;
      if (q0_data.size() != e0_data.size() || q8_data.size() != e0_data.size()) begin
         errors++;
         $display("FAIL b2b%0d_count got %0d/%0d want %0d",
                  randomize, q0_data.size(), q8_data.size(), e0_data.size());
      end else begin
         for (int k = 0; k < e0_data.size(); k++) begin
            checks++;
            if (q0_idx[k] != e_idx[k] || q0_data[k] != e0_data[k] || q0_last[k] != e_last[k]
                || q8_data[k] != e8_data[k] || q8_last[k] != e_last[k]) begin
               errors++;
               $display("FAIL b2b%0d_out[%0d] got d0=%0d d8=%0d l=%0d idx=%0d want %0d %0d l=%0d idx=%0d",
                        randomize, k, q0_data[k], q8_data[k], q0_last[k], q0_idx[k],
                        e0_data[k], e8_data[k], e_last[k], e_idx[k]);
            end
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      test_reset();
      test_ramp(1'b0);
      test_negative();
      test_saturate();
      test_ramp(1'b1);
      test_reset_mid_frame();
      test_back_to_back(2, 1'b0);
      test_back_to_back(4, 1'b1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
